// File: rtl/shapool_job_sequencer.sv
// Mining-job sequencer for the SHA pool: arms the pool, counts 64-round nonce
// batches, and captures the winning nonce or flags exhaustion of the nonce space.
module shapool_job_sequencer #(
   parameter int POOL_SIZE_LOG2 = 0,
   parameter int BATCH_WIDTH    = 24 - POOL_SIZE_LOG2,
   parameter int SUCCESS_LAG    = 1,
   parameter int IDX_W          = (POOL_SIZE_LOG2 > 0) ? POOL_SIZE_LOG2 : 1
) (
   input  logic             clk_in,
   input  logic             reset_n_in,
   input  logic             job_valid_in,
   output logic             job_ready_out,
   input  logic [7:0]       cfg_nonce_start_in,
   input  logic             abort_in,
   output logic             pool_reset_n_out,
   input  logic             pool_success_in,
   input  logic [IDX_W-1:0] pool_match_index_in,
   output logic [31:0]      result_nonce_out,
   output logic             result_valid_out,
   input  logic             result_ack_in,
   output logic             ready_n_out,
   output logic             busy_out,
   output logic             exhausted_out
);

   localparam int NONCE_BW = 24 - POOL_SIZE_LOG2;
   localparam int BCNT_W   = BATCH_WIDTH + 1;
   localparam logic [BCNT_W-1:0] LAG_B  = BCNT_W'(SUCCESS_LAG);
   localparam logic [BCNT_W-1:0] LAST_B = BCNT_W'((1 << BATCH_WIDTH) + SUCCESS_LAG - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_RUN,
      S_FOUND,
      S_EXH
   } state_e;

   state_e              state_q, state_d;
   logic [5:0]          round_q, round_d;
   logic [BCNT_W-1:0]   batch_q, batch_d;
   logic [7:0]          nonce_start_q, nonce_start_d;
   logic [31:0]         result_nonce_q, result_nonce_d;
   logic                job_ready_q, job_ready_d;
   logic                pool_reset_n_q, pool_reset_n_d;
   logic                result_valid_q, result_valid_d;
   logic                ready_n_q, ready_n_d;
   logic                busy_q, busy_d;
   logic                exhausted_q, exhausted_d;

   logic [BCNT_W-1:0]   batch_off;
   logic [NONCE_BW-1:0] batch_field;
   logic [31:0]         found_nonce;
   logic                success_qual;
   logic                last_round;

   // The flagged nonce entered the pool SUCCESS_LAG batches ago.
   assign batch_off    = batch_q - LAG_B;
   assign batch_field  = NONCE_BW'(batch_off);
   assign success_qual = pool_success_in && (batch_q >= LAG_B);
   assign last_round   = (round_q == 6'd63);

   generate
      if (POOL_SIZE_LOG2 > 0) begin : g_idx
         assign found_nonce = {nonce_start_q, batch_field,
                               pool_match_index_in[POOL_SIZE_LOG2-1:0]};
      end else begin : g_noidx
         logic unused_idx;
         assign unused_idx  = ^pool_match_index_in;
         assign found_nonce = {nonce_start_q, batch_field};
      end
   endgenerate

   always_comb begin
      state_d        = state_q;
      round_d        = round_q;
      batch_d        = batch_q;
      nonce_start_d  = nonce_start_q;
      result_nonce_d = result_nonce_q;

      if (abort_in && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (job_valid_in && job_ready_q) begin
                  state_d       = S_ARM;
                  nonce_start_d = cfg_nonce_start_in;
                  round_d       = 6'd0;
                  batch_d       = '0;
               end
            end
            S_ARM: state_d = S_RUN;
            S_RUN: begin
               round_d = round_q + 6'd1;
               if (last_round) begin
                  batch_d = batch_q + BCNT_W'(1);
               end
               // Success outranks exhaustion on the final round.
               if (success_qual) begin
                  state_d        = S_FOUND;
                  result_nonce_d = found_nonce;
               end else if (last_round && (batch_q == LAST_B)) begin
                  state_d = S_EXH;
               end
            end
            S_FOUND, S_EXH: begin
               if (result_ack_in) begin
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      job_ready_d    = (state_d == S_IDLE);
      pool_reset_n_d = (state_d == S_RUN);
      result_valid_d = (state_d == S_FOUND);
      ready_n_d      = (state_d != S_FOUND);
      busy_d         = (state_d == S_ARM) || (state_d == S_RUN);
      exhausted_d    = (state_d == S_EXH);
   end

   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         state_q        <= S_IDLE;
         round_q        <= 6'd0;
         batch_q        <= '0;
         nonce_start_q  <= 8'd0;
         result_nonce_q <= 32'd0;
         job_ready_q    <= 1'b1;
         pool_reset_n_q <= 1'b0;
         result_valid_q <= 1'b0;
         ready_n_q      <= 1'b1;
         busy_q         <= 1'b0;
         exhausted_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         round_q        <= round_d;
         batch_q        <= batch_d;
         nonce_start_q  <= nonce_start_d;
         result_nonce_q <= result_nonce_d;
         job_ready_q    <= job_ready_d;
         pool_reset_n_q <= pool_reset_n_d;
         result_valid_q <= result_valid_d;
         ready_n_q      <= ready_n_d;
         busy_q         <= busy_d;
         exhausted_q    <= exhausted_d;
      end
   end

   assign job_ready_out    = job_ready_q;
   assign pool_reset_n_out = pool_reset_n_q;
   assign result_nonce_out = result_nonce_q;
   assign result_valid_out = result_valid_q;
   assign ready_n_out      = ready_n_q;
   assign busy_out         = busy_q;
   assign exhausted_out    = exhausted_q;

endmodule

// File: tb/tb_shapool_job_sequencer.sv
// Bench for shapool_job_sequencer: three parameterisations share stimulus,
// a vector table covers nonce assembly, directed sequences and a random run check the rest.
module tb_shapool_job_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [2:0]  jv;
   logic [7:0]  cfg;
   logic        abort, succ, ack;
   logic [1:0]  idx;
   logic [2:0]  jr, prn, rv, rdn, bsy, exh;
   logic [31:0] nonce [3];

   int errors = 0;
   int checks = 0;

   // u_a: tiny nonce space, u_b: full 24-bit batch counter, u_c: four tracks
   shapool_job_sequencer #(.POOL_SIZE_LOG2(0), .BATCH_WIDTH(2)) u_a (
      .clk_in(clk), .reset_n_in(rst_n), .job_valid_in(jv[0]), .job_ready_out(jr[0]),
      .cfg_nonce_start_in(cfg), .abort_in(abort), .pool_reset_n_out(prn[0]),
      .pool_success_in(succ), .pool_match_index_in(idx[0:0]), .result_nonce_out(nonce[0]),
      .result_valid_out(rv[0]), .result_ack_in(ack), .ready_n_out(rdn[0]),
      .busy_out(bsy[0]), .exhausted_out(exh[0]));

   shapool_job_sequencer #(.POOL_SIZE_LOG2(0), .BATCH_WIDTH(24)) u_b (
      .clk_in(clk), .reset_n_in(rst_n), .job_valid_in(jv[1]), .job_ready_out(jr[1]),
      .cfg_nonce_start_in(cfg), .abort_in(abort), .pool_reset_n_out(prn[1]),
      .pool_success_in(succ), .pool_match_index_in(idx[0:0]), .result_nonce_out(nonce[1]),
      .result_valid_out(rv[1]), .result_ack_in(ack), .ready_n_out(rdn[1]),
      .busy_out(bsy[1]), .exhausted_out(exh[1]));

   shapool_job_sequencer #(.POOL_SIZE_LOG2(2), .BATCH_WIDTH(22)) u_c (
      .clk_in(clk), .reset_n_in(rst_n), .job_valid_in(jv[2]), .job_ready_out(jr[2]),
      .cfg_nonce_start_in(cfg), .abort_in(abort), .pool_reset_n_out(prn[2]),
      .pool_success_in(succ), .pool_match_index_in(idx), .result_nonce_out(nonce[2]),
      .result_valid_out(rv[2]), .result_ack_in(ack), .ready_n_out(rdn[2]),
      .busy_out(bsy[2]), .exhausted_out(exh[2]));

   typedef struct {
      int          dut;
      logic [7:0]  ns;
      int          cyc;
      logic [1:0]  mi;
      logic [31:0] exp_nonce;
   } vec_t;

   vec_t vecs [6];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, exp);
      end
   endtask

   // Leaves the DUT at the start of RUN cycle 0 (pool round 0).
   task automatic start_job(input int d, input logic [7:0] ns);
      cfg   = ns;
      jv[d] = 1'b1;
      tick();
      jv[d] = 1'b0;
      chk("arm_busy", 32'(bsy[d]), 32'd1);
      chk("arm_pool_held", 32'(prn[d]), 32'd0);
      tick();
      chk("run_pool_released", 32'(prn[d]), 32'd1);
   endtask

   // Reference model for u_a, tracked as elapsed RUN cycles rather than counters.
   int          m_ph;   // 0 idle, 1 arm, 2 run, 3 found, 4 exhausted
   int          m_t;
   int          m_b;
   logic [7:0]  m_ns;
   logic [31:0] m_nonce;
   logic [5:0]  exp6, act6;

   initial begin
      rst_n = 1'b0; jv = '0; cfg = '0; abort = 0; succ = 0; ack = 0; idx = '0;
      vecs[0] = '{1, 8'h00, 197, 2'd0, 32'h0000_0002};
      vecs[1] = '{1, 8'hA5,  64, 2'd0, 32'hA500_0000};
      vecs[2] = '{2, 8'h12, 130, 2'd3, 32'h1200_0007};
      vecs[3] = '{2, 8'hFF,  64, 2'd2, 32'hFF00_0002};
      vecs[4] = '{0, 8'h5A, 319, 2'd0, 32'h5A00_0003};
      vecs[5] = '{0, 8'h01, 100, 2'd0, 32'h0100_0000};

      #12;
      for (int d = 0; d < 3; d++) begin
         chk("rst_outputs", {26'd0, jr[d], prn[d], rv[d], rdn[d], bsy[d], exh[d]}, 32'b100100);
         chk("rst_nonce", nonce[d], 32'd0);
      end
      @(negedge clk) rst_n = 1'b1;
      tick();

      for (int v = 0; v < 6; v++) begin
         start_job(vecs[v].dut, vecs[v].ns);
         repeat (vecs[v].cyc) tick();
         idx  = vecs[v].mi;
         succ = 1'b1;
         tick();
         succ = 1'b0;
         $display("vec %0d dut %0d cycle %0d nonce 0x%08h", v, vecs[v].dut, vecs[v].cyc, nonce[vecs[v].dut]);
         chk("vec_nonce", nonce[vecs[v].dut], vecs[v].exp_nonce);
         chk("vec_found_flags", {28'd0, rv[vecs[v].dut], rdn[vecs[v].dut], prn[vecs[v].dut], exh[vecs[v].dut]}, 32'b1000);
         ack = 1'b1;
         tick();
         ack = 1'b0;
         chk("vec_ack_flags", {28'd0, jr[vecs[v].dut], rv[vecs[v].dut], rdn[vecs[v].dut], bsy[vecs[v].dut]}, 32'b1010);
         chk("vec_nonce_held", nonce[vecs[v].dut], vecs[v].exp_nonce);
      end

      // Success during batch 0 is discarded while the pipeline fills.
      start_job(0, 8'hA5);
      repeat (10) tick();
      succ = 1'b1;
      tick();
      succ = 1'b0;
      repeat (20) tick();
      $display("early success: busy=%0b valid=%0b", bsy[0], rv[0]);
      chk("early_succ_flags", {29'd0, bsy[0], rv[0], prn[0]}, 32'b101);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_run_flags", {29'd0, jr[0], bsy[0], prn[0]}, 32'b100);

      // Exhaustion lands exactly at the end of RUN cycle 319.
      start_job(0, 8'h77);
      repeat (319) tick();
      chk("exh_not_early", 32'(exh[0]), 32'd0);
      tick();
      $display("exhaustion: exhausted=%0b ready_n=%0b", exh[0], rdn[0]);
      chk("exh_flags", {28'd0, exh[0], rdn[0], prn[0], bsy[0]}, 32'b1100);
      jv[0] = 1'b1;
      tick();
      jv[0] = 1'b0;
      chk("exh_ignores_job", {30'd0, jr[0], exh[0]}, 32'b01);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk("exh_ack", {30'd0, jr[0], exh[0]}, 32'b10);

      // FOUND ignores new jobs; abort together with ack returns to IDLE.
      start_job(2, 8'h12);
      repeat (130) tick();
      idx  = 2'd3;
      succ = 1'b1;
      tick();
      succ = 1'b0;
      chk("found_nonce", nonce[2], 32'h1200_0007);
      jv[2] = 1'b1;
      tick();
      jv[2] = 1'b0;
      tick();
      chk("found_ignores_job", {30'd0, jr[2], rv[2]}, 32'b01);
      abort = 1'b1; ack = 1'b1;
      tick();
      abort = 1'b0; ack = 1'b0;
      $display("abort+ack in found: ready=%0b ready_n=%0b valid=%0b", jr[2], rdn[2], rv[2]);
      chk("abort_ack_flags", {29'd0, jr[2], rdn[2], rv[2]}, 32'b110);
      jv[2] = 1'b1; abort = 1'b1;
      tick();
      jv[2] = 1'b0;
      chk("idle_abort_accepts", 32'(bsy[2]), 32'd1);
      tick();
      abort = 1'b0;
      chk("abort_arm", {30'd0, jr[2], bsy[2]}, 32'b10);

      // Asynchronous reset mid-RUN.
      start_job(0, 8'h33);
      repeat (70) tick();
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_outputs", {26'd0, jr[0], prn[0], rv[0], rdn[0], bsy[0], exh[0]}, 32'b100100);
      chk("async_rst_nonce", nonce[0], 32'd0);
      @(negedge clk) rst_n = 1'b1;
      tick();

      // Random run of u_a against the model.
      m_ph = 0; m_t = 0; m_ns = '0; m_nonce = '0;
      for (int i = 0; i < 6000; i++) begin
         jv[0] = ($urandom_range(3) == 0);
         abort = ($urandom_range(299) == 0);
         succ  = ($urandom_range(i < 3000 ? 149 : 799) == 0);
         ack   = ($urandom_range(7) == 0);
         cfg   = 8'($urandom);
         if (m_ph == 0) begin
            if (jv[0]) begin m_ph = 1; m_ns = cfg; end
         end else if (abort) begin
            m_ph = 0;
         end else if (m_ph == 1) begin
            m_ph = 2; m_t = 0;
         end else if (m_ph == 2) begin
            m_b = m_t / 64;
            if (succ && m_b >= 1) begin
               m_nonce = {m_ns, 24'(m_b - 1)};
               m_ph = 3;
               $display("rand %0d: found nonce 0x%08h", i, m_nonce);
            end else if (m_t == 64 * (4 + 1) - 1) begin
               m_ph = 4;
               $display("rand %0d: exhausted", i);
            end else begin
               m_t++;
            end
         end else if (ack) begin
            m_ph = 0;
         end
         tick();
         exp6 = {m_ph == 0, m_ph == 2, m_ph == 3, m_ph != 3, m_ph == 1 || m_ph == 2, m_ph == 4};
         act6 = {jr[0], prn[0], rv[0], rdn[0], bsy[0], exh[0]};
         chk("rand_flags", 32'(act6), 32'(exp6));
         chk("rand_nonce", nonce[0], m_nonce);
      end
      jv = '0; abort = 0; succ = 0; ack = 0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
